vga_controle_embarcacoes: RTL and testbench
===========================================

# vga_controle_embarcacoes

Fleet placement controller for the VGA battleship display. It accepts place and remove commands for the five ships over a valid/ready handshake, then checks bounds and overlap against an 8x8 occupancy map. It sequences the per-cell writes into shadow position vectors and commits them to the per-ship renderers only during blanking, so a ship never tears mid-frame. It sits between the game logic and the five ship renderer blocks (Submarino, Cruzador, Hidroaviao, Encouracado, Porta-avioes).

## Interface
- TAM_0..TAM_4, defaults 1,2,3,4,5: cell count of ships 0..4. Legal range 1..7.
- clk  in  1  system clock, single domain.
- rst_n  in  1  synchronous, active-low reset.
- areaAtiva  in  1  VGA active-area flag. Low means blanking.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  0 = place, 1 = remove.
- cmd_navio  in  3  ship id, 0..4.
- cmd_x, cmd_y  in  4 each  start cell, game coordinates 1..8.
- cmd_vertical  in  1  0: cells advance in +X; 1: cells advance in +Y.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  2  0 ok, 1 out of bounds, 2 overlap, 3 bad id / bad state.
- posicoes_0..posicoes_4  out  64 each  committed position vectors, one per renderer.
- ocupacao  out  64  occupancy map. Bit (y-1)*8+(x-1) is set when a cell holds a ship.

## Operation
- Vector format for cell k (k = 0..6):
  - X is bits [8k+6 -:4].
  - Y is bits [8k+10 -:4].
  - Bits [2:0] hold the ship size when placed, 0 when absent.
  - Cells k >= N replicate cell N-1, so renderers never see X or Y = 0 for a placed ship.
  - An absent ship's vector is all zeros.
- Registers:
  - A shadow copy of each of the five vectors.
  - A per-ship placed flag.
  - The occupancy map, updated immediately, not deferred to blanking.
  - Cell counter k (3 bits) and current cell (cx, cy).
- FSM states: IDLE, CHECK, WRITE, CLEAR, WAIT_VB, COMMIT, RESP_ERR.
- IDLE: cmd_ready=1. A handshake (cmd_valid & cmd_ready) latches the command, sets N=TAM_id, k=0, and (cx, cy) = start cell.
  - Go to RESP_ERR with err 3 if any of:
    - cmd_navio > 4;
    - place of an already-placed ship;
    - remove of an unplaced ship.
  - Otherwise place goes to CHECK and remove goes to CLEAR.
- CHECK, one cell per cycle:
  - At k=0, go to RESP_ERR err 1 if start < 1, start > 8, or start+N-1 > 8 on the advancing axis. Use 5-bit arithmetic so no wrap.
  - Any other X/Y value of 0 or > 8 is also err 1.
  - If the occupancy bit of (cx, cy) is set, go to RESP_ERR err 2.
  - After cell N-1 passes, reset k and go to WRITE.
  - No state is modified during CHECK.
- WRITE, one cell per cycle:
  - Write cell k into the shadow vector and set its occupancy bit.
  - At k=N-1, also fill the replica cells, set bits [2:0]=N, set placed, then go to WAIT_VB.
- CLEAR, one cell per cycle:
  - Read cell k from the shadow vector and clear its occupancy bit.
  - At k=N-1, zero the shadow vector, clear placed, then go to WAIT_VB.
- WAIT_VB: hold until areaAtiva is sampled 0, then go to COMMIT.
- COMMIT: copy the shadow vector of the commanded ship to its posicoes output, pulse resp_valid with err 0, return to IDLE.
- RESP_ERR: pulse resp_valid with resp_err set, return to IDLE. Shadow, occupancy and outputs are untouched.
- cmd_valid while cmd_ready=0 is ignored; the command is not queued.
- areaAtiva is ignored outside WAIT_VB.

## Timing
- Reset values:
  - posicoes_* = 0, ocupacao = 0, placed flags = 0.
  - resp_valid = 0, resp_err = 0, cmd_ready = 1, state IDLE.
- rst_n low mid-operation aborts the command; all of the above apply on that edge. No response is issued.
- Cycle offsets are counted from handshake cycle T:
  - Immediate error (err 3): resp_valid at T+1.
  - CHECK cell k is evaluated at T+1+k. A failure there gives resp_valid at T+2+k.
  - Place success: WRITE runs T+N+1..T+2N. With areaAtiva already low, resp_valid and the new posicoes are visible together at T+2N+2.
  - Remove: CLEAR runs T+1..T+N. resp_valid is at T+N+2 with areaAtiva low.
- Each occupancy bit is visible one cycle after its WRITE or CLEAR cycle.
- posicoes_* change only in the cycle resp_valid is high, and only while areaAtiva=0.
- cmd_ready returns to 1 in the cycle after resp_valid.

## Test plan
- Reset: hold rst_n=0 for 2 cycles, release -> all posicoes and ocupacao = 0, cmd_ready=1, resp_valid=0.
- Place ship 3 (N=4) at (2,5) horizontal, areaAtiva=0:
  - resp_valid at T+10, err 0.
  - posicoes_3 cells X=2,3,4,5 with Y=5. Cells 4..6 equal (5,5). Bits [2:0]=4.
  - ocupacao bits 33..36 set.
- Bounds: place ship 4 at (5,1) horizontal -> err 1 at T+2, no register change.
- Overlap: after the placement above, place ship 1 at (3,4) vertical -> err 2 at T+3 (cell (3,5) hit). ocupacao is unchanged.
- Blanking hold: place ship 0 at (8,8) with areaAtiva=1 for 20 cycles:
  - ocupacao bit 63 is set.
  - posicoes_0 stays 0 and there is no resp_valid.
  - Drop areaAtiva -> resp_valid 2 cycles later with posicoes_0 updated.
- Remove/re-place and reset abort:
  - Remove ship 3 -> bits 33..36 cleared, posicoes_3=0.
  - Place ship 3 again -> err 0.
  - Assert rst_n=0 during WRITE -> everything is cleared and no resp_valid is issued.

Source files
------------

// File: rtl/vga_controle_embarcacoes.sv
// Fleet placement controller: validates place/remove commands for five ships against an
// 8x8 occupancy map and commits their position vectors to the renderers only during blanking.
module vga_controle_embarcacoes #(
   parameter int TAM_0 = 1,
   parameter int TAM_1 = 2,
   parameter int TAM_2 = 3,
   parameter int TAM_3 = 4,
   parameter int TAM_4 = 5
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_area_ativa,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic        i_cmd_op,
   input  logic [2:0]  i_cmd_navio,
   input  logic [3:0]  i_cmd_x,
   input  logic [3:0]  i_cmd_y,
   input  logic        i_cmd_vertical,
   output logic        o_resp_valid,
   output logic [1:0]  o_resp_err,
   output logic [63:0] o_posicoes_0,
   output logic [63:0] o_posicoes_1,
   output logic [63:0] o_posicoes_2,
   output logic [63:0] o_posicoes_3,
   output logic [63:0] o_posicoes_4,
   output logic [63:0] o_ocupacao
);

   // state     | meaning
   // S_IDLE    | ready for a command
   // S_CHECK   | bounds/overlap test, one cell per cycle
   // S_WRITE   | write shadow cell k and its occupancy bit
   // S_CLEAR   | clear occupancy of shadow cell k
   // S_WAIT_VB | hold shadow until blanking
   // S_COMMIT  | shadow -> renderer vector, ok response
   // S_RESP_ERR| error response, nothing modified
   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_WRITE, S_CLEAR, S_WAIT_VB, S_COMMIT, S_RESP_ERR
   } state_t;

   state_t      r_state, w_next;
   logic [1:0]  r_err, w_err;
   logic [2:0]  r_id, r_k, r_n, w_tam;
   logic        r_vert;
   logic [3:0]  r_x0, r_y0, r_cx, r_cy;
   logic [4:0]  r_placed;
   logic [63:0] r_occ;
   logic [63:0] r_shadow [5];
   logic [63:0] r_pos    [5];

   logic        w_id_ok, w_placed_sel, w_cmd_bad;
   logic [63:0] w_sh, w_wr_vec;
   logic [5:0]  w_base, w_occ_idx;
   logic [3:0]  w_sx, w_sy, w_cur_x, w_cur_y;
   logic [4:0]  w_end_x, w_end_y;
   logic        w_bad_coord, w_bad_span, w_last, w_hit;

   always_comb begin
      w_tam = 3'd0;
      case (i_cmd_navio)
         3'd0:    w_tam = 3'(TAM_0);
         3'd1:    w_tam = 3'(TAM_1);
         3'd2:    w_tam = 3'(TAM_2);
         3'd3:    w_tam = 3'(TAM_3);
         3'd4:    w_tam = 3'(TAM_4);
         default: w_tam = 3'd0;
      endcase
   end

   assign w_id_ok      = (i_cmd_navio <= 3'd4);
   assign w_placed_sel = w_id_ok && r_placed[i_cmd_navio];
   assign w_cmd_bad    = !w_id_ok || (i_cmd_op ? !w_placed_sel : w_placed_sel);

   // Removal walks the cells stored in the shadow; placement walks the counter position.
   assign w_sh      = r_shadow[r_id];
   assign w_base    = {r_k, 3'b000};
   assign w_sx      = w_sh[w_base + 6'd3 +: 4];
   assign w_sy      = w_sh[w_base + 6'd7 +: 4];
   assign w_cur_x   = (r_state == S_CLEAR) ? w_sx : r_cx;
   assign w_cur_y   = (r_state == S_CLEAR) ? w_sy : r_cy;
   assign w_occ_idx = 6'(({2'b00, w_cur_y} - 6'd1) * 6'd8 + {2'b00, w_cur_x} - 6'd1);
   assign w_hit     = r_occ[w_occ_idx];

   assign w_end_x     = {1'b0, r_cx} + {2'b00, r_n} - 5'd1;
   assign w_end_y     = {1'b0, r_cy} + {2'b00, r_n} - 5'd1;
   assign w_bad_coord = (r_cx == 4'd0) || (r_cx > 4'd8) || (r_cy == 4'd0) || (r_cy > 4'd8);
   assign w_bad_span  = (r_k == 3'd0) && (r_vert ? (w_end_y > 5'd8) : (w_end_x > 5'd8));
   assign w_last      = (r_k == r_n - 3'd1);

   always_comb begin
      w_wr_vec = w_sh;
      for (int j = 0; j < 7; j++) begin
         if ((3'(j) == r_k) || (w_last && (3'(j) > r_k))) begin
            w_wr_vec[8*j+3 +: 4] = r_cx;
            w_wr_vec[8*j+7 +: 4] = r_cy;
         end
      end
      if (w_last) w_wr_vec[2:0] = r_n;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_err  = 2'd0;
      case (r_state)
         S_IDLE: begin
            if (i_cmd_valid) begin
               if (w_cmd_bad) begin
                  w_next = S_RESP_ERR;
                  w_err  = 2'd3;
               end else if (i_cmd_op) begin
                  w_next = S_CLEAR;
               end else begin
                  w_next = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            if (w_bad_coord || w_bad_span) begin
               w_next = S_RESP_ERR;
               w_err  = 2'd1;
            end else if (w_hit) begin
               w_next = S_RESP_ERR;
               w_err  = 2'd2;
            end else if (w_last) begin
               w_next = S_WRITE;
            end
         end
         S_WRITE, S_CLEAR: if (w_last) w_next = S_WAIT_VB;
         S_WAIT_VB:        if (!i_area_ativa) w_next = S_COMMIT;
         S_COMMIT, S_RESP_ERR: w_next = S_IDLE;
         default:          w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_err    <= 2'd0;
         r_id     <= 3'd0;
         r_k      <= 3'd0;
         r_n      <= 3'd0;
         r_vert   <= 1'b0;
         r_x0     <= 4'd0;
         r_y0     <= 4'd0;
         r_cx     <= 4'd0;
         r_cy     <= 4'd0;
         r_placed <= 5'd0;
         r_occ    <= 64'd0;
         for (int i = 0; i < 5; i++) begin
            r_shadow[i] <= 64'd0;
            r_pos[i]    <= 64'd0;
         end
      end else begin
         if (w_next == S_RESP_ERR) r_err <= w_err;
         case (r_state)
            S_IDLE: begin
               if (i_cmd_valid) begin
                  r_id   <= i_cmd_navio;
                  r_n    <= w_tam;
                  r_k    <= 3'd0;
                  r_vert <= i_cmd_vertical;
                  r_x0   <= i_cmd_x;
                  r_y0   <= i_cmd_y;
                  r_cx   <= i_cmd_x;
                  r_cy   <= i_cmd_y;
               end
            end
            S_CHECK: begin
               if (w_next == S_WRITE) begin
                  r_k  <= 3'd0;
                  r_cx <= r_x0;
                  r_cy <= r_y0;
               end else if (w_next == S_CHECK) begin
                  r_k <= r_k + 3'd1;
                  if (r_vert) r_cy <= r_cy + 4'd1;
                  else        r_cx <= r_cx + 4'd1;
               end
            end
            S_WRITE: begin
               r_occ[w_occ_idx] <= 1'b1;
               r_shadow[r_id]   <= w_wr_vec;
               if (w_last) begin
                  r_placed[r_id] <= 1'b1;
               end else begin
                  r_k <= r_k + 3'd1;
                  if (r_vert) r_cy <= r_cy + 4'd1;
                  else        r_cx <= r_cx + 4'd1;
               end
            end
            S_CLEAR: begin
               r_occ[w_occ_idx] <= 1'b0;
               r_k              <= r_k + 3'd1;
               if (w_last) begin
                  r_shadow[r_id] <= 64'd0;
                  r_placed[r_id] <= 1'b0;
               end
            end
            S_WAIT_VB: if (!i_area_ativa) r_pos[r_id] <= r_shadow[r_id];
            default: ;
         endcase
      end
   end

   assign o_cmd_ready  = (r_state == S_IDLE);
   assign o_resp_valid = (r_state == S_COMMIT) || (r_state == S_RESP_ERR);
   assign o_resp_err   = (r_state == S_RESP_ERR) ? r_err : 2'd0;
   assign o_posicoes_0 = r_pos[0];
   assign o_posicoes_1 = r_pos[1];
   assign o_posicoes_2 = r_pos[2];
   assign o_posicoes_3 = r_pos[3];
   assign o_posicoes_4 = r_pos[4];
   assign o_ocupacao   = r_occ;

endmodule

// File: tb/tb_vga_controle_embarcacoes.sv
// Scoreboard bench for the fleet placement controller: a board-level model predicts each
// response (error code, latency, all position vectors, occupancy) and a monitor checks it.
module tb_vga_controle_embarcacoes;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        area_ativa = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_op = 1'b0;
   logic [2:0]  cmd_navio = 3'd0;
   logic [3:0]  cmd_x = 4'd0;
   logic [3:0]  cmd_y = 4'd0;
   logic        cmd_vertical = 1'b0;
   logic        cmd_ready, resp_valid;
   logic [1:0]  resp_err;
   logic [63:0] pos0, pos1, pos2, pos3, pos4, ocupacao;

   vga_controle_embarcacoes dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_area_ativa(area_ativa),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
      .i_cmd_navio(cmd_navio), .i_cmd_x(cmd_x), .i_cmd_y(cmd_y),
      .i_cmd_vertical(cmd_vertical), .o_resp_valid(resp_valid), .o_resp_err(resp_err),
      .o_posicoes_0(pos0), .o_posicoes_1(pos1), .o_posicoes_2(pos2),
      .o_posicoes_3(pos3), .o_posicoes_4(pos4), .o_ocupacao(ocupacao)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]       err;
      int               lat;
      int               t0;
      logic [4:0][63:0] pos;
      logic [63:0]      occ;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   resp_cnt = 0;
   int   last_resp_cyc = 0;

   // Board model: ship cells as coordinates, occupancy as a 64-entry bitmap.
   logic [63:0]      m_occ;
   logic [4:0][63:0] m_pos;
   bit   [4:0]       m_placed;
   int               m_cx [5][7];
   int               m_cy [5][7];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic model_reset();
      m_occ = '0;
      m_pos = '0;
      m_placed = '0;
   endtask

   task automatic model_cmd(input bit op, input int id, input int x, input int y, input bit vert,
                            output logic [1:0] err, output int lat);
      int n, ex, ey, cx, cy, c;
      int xs [7];
      int ys [7];
      logic [63:0] vec;
      err = 2'd0;
      lat = 0;
      if (id > 4) begin err = 2'd3; lat = 1; return; end
      if (op == 1'b0 && m_placed[id]) begin err = 2'd3; lat = 1; return; end
      if (op == 1'b1 && !m_placed[id]) begin err = 2'd3; lat = 1; return; end
      n = id + 1;
      if (op == 1'b1) begin
         for (int k = 0; k < n; k++) m_occ[(m_cy[id][k] - 1) * 8 + m_cx[id][k] - 1] = 1'b0;
         m_placed[id] = 1'b0;
         m_pos[id] = '0;
         lat = n + 2;
         return;
      end
      ex = vert ? x : x + n - 1;
      ey = vert ? y + n - 1 : y;
      if (x < 1 || x > 8 || y < 1 || y > 8 || ex > 8 || ey > 8) begin err = 2'd1; lat = 2; return; end
      for (int k = 0; k < n; k++) begin
         xs[k] = vert ? x : x + k;
         ys[k] = vert ? y + k : y;
         if (m_occ[(ys[k] - 1) * 8 + xs[k] - 1]) begin err = 2'd2; lat = 2 + k; return; end
      end
      vec = 64'(n);
      for (int k = 0; k < 7; k++) begin
         c = (k < n) ? k : n - 1;
         vec = vec | (64'(xs[c]) << (8 * k + 3)) | (64'(ys[c]) << (8 * k + 7));
         if (k < n) begin
            m_cx[id][k] = xs[k];
            m_cy[id][k] = ys[k];
            m_occ[(ys[k] - 1) * 8 + xs[k] - 1] = 1'b1;
         end
      end
      m_placed[id] = 1'b1;
      m_pos[id] = vec;
      lat = 2 * n + 2;
   endtask

   // Monitor: samples 1 time unit after each active edge.
   initial begin
      logic [4:0][63:0] cur, prev;
      bit ready_chk;
      exp_t e;
      prev = '0;
      ready_chk = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cur = {pos4, pos3, pos2, pos1, pos0};
         if (!rst_n) begin
            prev = cur;
            ready_chk = 1'b0;
            continue;
         end
         if (ready_chk) check("ready_after_resp", 64'(cmd_ready), 64'd1);
         ready_chk = 1'b0;
         if (resp_valid) begin
            resp_cnt++;
            last_resp_cyc = cyc;
            ready_chk = 1'b1;
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_resp: got resp err %0d at cycle %0d, expected none", resp_err, cyc);
            end else begin
               e = sb_q.pop_front();
               check("resp_err", 64'(resp_err), 64'(e.err));
               if (e.lat >= 0) check("resp_latency", 64'(cyc - e.t0), 64'(e.lat));
               for (int i = 0; i < 5; i++) check($sformatf("resp_pos%0d", i), cur[i], e.pos[i]);
               check("resp_occ", ocupacao, e.occ);
            end
         end else if (cur != prev) begin
            n_tests++;
            n_fail++;
            $display("FAIL pos_change_no_resp: got %h expected %h", cur, prev);
         end
         prev = cur;
      end
   end

   task automatic wait_idle();
      int g;
      g = 0;
      @(negedge clk);
      while (!(sb_q.size() == 0 && cmd_ready === 1'b1)) begin
         @(negedge clk);
         g++;
         if (g > 400) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got queue %0d ready %0b, expected queue 0 ready 1", sb_q.size(), cmd_ready);
            sb_q.delete();
            return;
         end
      end
   endtask

   task automatic send(input bit op, input int id, input int x, input int y, input bit vert,
                       input bit area_hi, input bit junk);
      exp_t e;
      logic [1:0] err;
      int lat;
      wait_idle();
      area_ativa = area_hi;
      model_cmd(op, id, x, y, vert, err, lat);
      e.err = err;
      e.lat = (area_hi && err == 2'd0) ? -1 : lat;
      e.t0  = cyc;
      e.pos = m_pos;
      e.occ = m_occ;
      sb_q.push_back(e);
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_navio = 3'(id);
      cmd_x = 4'(x);
      cmd_y = 4'(y);
      cmd_vertical = vert;
      @(negedge clk);
      if (junk) begin
         cmd_op = 1'($urandom);
         cmd_navio = 3'($urandom_range(0, 4));
         cmd_x = 4'($urandom_range(1, 8));
         cmd_y = 4'($urandom_range(1, 8));
         @(negedge clk);
      end
      cmd_valid = 1'b0;
   endtask

   task automatic check_all_clear(input string tag);
      check({tag, "_pos0"}, pos0, 64'd0);
      check({tag, "_pos1"}, pos1, 64'd0);
      check({tag, "_pos2"}, pos2, 64'd0);
      check({tag, "_pos3"}, pos3, 64'd0);
      check({tag, "_pos4"}, pos4, 64'd0);
      check({tag, "_occ"}, ocupacao, 64'd0);
      check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
      check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
   endtask

   initial begin
      int xs [7];
      logic [63:0] vec3;
      int cnt0, d, g;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_all_clear("reset");

      // Ship 3 (4 cells) at (2,5) horizontal; bit 33 appears one cycle after the first write.
      send(1'b0, 3, 2, 5, 1'b0, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      check("occ_first_write", 64'(ocupacao[36:33]), 64'h1);
      wait_idle();
      xs = '{2, 3, 4, 5, 5, 5, 5};
      vec3 = 64'd4;
      for (int k = 0; k < 7; k++) vec3 = vec3 | (64'(xs[k]) << (8 * k + 3)) | (64'd5 << (8 * k + 7));
      check("pos3_place", pos3, vec3);
      check("occ_place", ocupacao, 64'h0000_001E_0000_0000);

      send(1'b0, 4, 5, 1, 1'b0, 1'b0, 1'b0);
      send(1'b0, 1, 3, 4, 1'b1, 1'b0, 1'b0);
      send(1'b0, 5, 1, 1, 1'b0, 1'b0, 1'b0);
      send(1'b1, 4, 1, 1, 1'b0, 1'b0, 1'b1);
      send(1'b0, 3, 1, 1, 1'b0, 1'b0, 1'b0);

      // Blanking hold on ship 0 at (8,8).
      send(1'b0, 0, 8, 8, 1'b0, 1'b1, 1'b0);
      cnt0 = resp_cnt;
      repeat (20) @(negedge clk);
      check("hold_occ63", 64'(ocupacao[63]), 64'd1);
      check("hold_pos0", pos0, 64'd0);
      check("hold_no_resp", 64'(resp_cnt), 64'(cnt0));
      area_ativa = 1'b0;
      d = cyc;
      g = 0;
      while (resp_cnt == cnt0 && g < 10) begin @(negedge clk); g++; end
      check("hold_resp_seen", 64'(resp_cnt), 64'(cnt0 + 1));
      check("hold_resp_delay_ok", 64'((last_resp_cyc - d >= 1) && (last_resp_cyc - d <= 2)), 64'd1);

      send(1'b1, 3, 0, 0, 1'b0, 1'b0, 1'b0);
      wait_idle();
      check("remove_occ_bits", 64'(ocupacao[36:33]), 64'd0);
      check("remove_pos3", pos3, 64'd0);
      send(1'b0, 3, 2, 5, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of WRITE for ship 2 (WRITE occupies T+4..T+6).
      send(1'b0, 2, 1, 1, 1'b0, 1'b0, 1'b0);
      cnt0 = resp_cnt;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sb_q.delete();
      model_reset();
      repeat (10) @(negedge clk);
      check_all_clear("abort");
      check("abort_no_resp", 64'(resp_cnt), 64'(cnt0));

      for (int i = 0; i < 80; i++) begin
         bit hi;
         hi = ($urandom_range(0, 4) == 0);
         send(1'($urandom_range(0, 2) == 0), $urandom_range(0, 5), $urandom_range(0, 9),
              $urandom_range(0, 9), 1'($urandom), hi, 1'($urandom_range(0, 3) == 0));
         if (hi) begin
            repeat ($urandom_range(0, 8)) @(negedge clk);
            area_ativa = 1'b0;
         end
      end
      wait_idle();
      check("final_occ", ocupacao, m_occ);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
